// File: rtl/maxpool_flatten_engine.sv
// POOLxPOOL max-pool over every layer-0 channel, written to layer-1 memories,
// with an optional channel-interleaved flatten copy written to layer-2 memory.
module maxpool_flatten_engine #(
    parameter int DW    = 20,
    parameter int IMG_W = 64,
    parameter int POOL  = 2,
    parameter int CH    = 2,
    parameter int SELW  = 3,
    parameter int AW    = $clog2(IMG_W * IMG_W)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            ready_i,
    input  logic            flat_en_i,
    output logic            busy_o,
    output logic            crd_o,
    output logic [AW-1:0]   caddr_rd_o,
    input  logic [DW-1:0]   cdata_rd_i,
    output logic            cwr_o,
    output logic [AW-1:0]   caddr_wr_o,
    output logic [DW-1:0]   cdata_wr_o,
    output logic [SELW-1:0] csel_o
);

    localparam int OW  = IMG_W / POOL;
    localparam int PW  = $clog2(POOL);
    localparam int KW  = 2 * PW;
    localparam int RW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [KW-1:0]  K_LAST  = KW'(POOL * POOL - 1);
    localparam logic [RW-1:0]  O_LAST  = RW'(OW - 1);
    localparam logic [CHW-1:0] CH_LAST = CHW'(CH - 1);

    if ((IMG_W < POOL) || ((IMG_W & (IMG_W - 1)) != 0) || ((POOL != 2) && (POOL != 4)) ||
        (CH < 1) || (2 * CH + 1 > 2 ** SELW - 1) || (OW * OW * CH > 2 ** AW)) begin : g_param_check
        $error("maxpool_flatten_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WR_L1, WR_L2} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   r_q, r_d, c_q, c_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [KW-1:0]   k_q, k_d;
    logic            flat_q, flat_d, busy_q, busy_d;
    logic            pend_q, pend_first_q;
    logic [DW-1:0]   acc_q, fold_s;
    logic            crd_q, crd_d, cwr_q, cwr_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
    logic [SELW-1:0] csel_q, csel_d;
    logic            adv_s, last_s;

    // Window element k = i*POOL+j of pooled cell (r,c) in the layer-0 image.
    function automatic logic [AW-1:0] rd_addr(input logic [RW-1:0] r, input logic [RW-1:0] c,
                                              input logic [KW-1:0] k);
        logic [AW-1:0] row, col;
        row = AW'(r) * AW'(POOL) + AW'(k[KW-1:PW]);
        col = AW'(c) * AW'(POOL) + AW'(k[PW-1:0]);
        return row * AW'(IMG_W) + col;
    endfunction

    function automatic logic [AW-1:0] l1_addr(input logic [RW-1:0] r, input logic [RW-1:0] c);
        return AW'(r) * AW'(OW) + AW'(c);
    endfunction

    // The word returned this cycle belongs to the read issued last cycle.
    always_comb begin
        fold_s = acc_q;
        if (pend_q && (pend_first_q || ($signed(cdata_rd_i) > $signed(acc_q)))) begin
            fold_s = cdata_rd_i;
        end else begin
            fold_s = acc_q;
        end
    end

    // Sequencing: state, window index and the (r, c, ch) group counters.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        ch_d    = ch_q;
        k_d     = k_q;
        flat_d  = flat_q;
        busy_d  = busy_q;
        adv_s   = 1'b0;
        last_s  = (r_q == O_LAST) && (c_q == O_LAST) && (ch_q == CH_LAST);
        case (state_q)
            IDLE: begin
                if (ready_i) begin
                    state_d = READ;
                    flat_d  = flat_en_i;
                    busy_d  = 1'b1;
                    r_d     = '0;
                    c_d     = '0;
                    ch_d    = '0;
                    k_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN:   state_d = WR_L1;
            WR_L1: begin
                if (flat_q) begin
                    state_d = WR_L2;
                end else begin
                    adv_s = 1'b1;
                end
            end
            WR_L2:   adv_s = 1'b1;
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (adv_s) begin
            k_d = '0;
            if (last_s) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else if (ch_q != CH_LAST) begin
                state_d = READ;
                ch_d    = ch_q + CHW'(1);
            end else if (c_q != O_LAST) begin
                state_d = READ;
                ch_d    = '0;
                c_d     = c_q + RW'(1);
            end else begin
                state_d = READ;
                ch_d    = '0;
                c_d     = '0;
                r_d     = r_q + RW'(1);
            end
        end else begin
            k_d = k_d;
        end
    end

    // Bus outputs for the coming cycle, derived from the next state.
    always_comb begin
        crd_d      = (state_d == READ);
        cwr_d      = (state_d == WR_L1) || (state_d == WR_L2);
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        case (state_d)
            READ: begin
                caddr_rd_d = rd_addr(r_d, c_d, k_d);
                csel_d     = SELW'(1) + SELW'(ch_d);
            end
            WR_L1: begin
                caddr_wr_d = l1_addr(r_d, c_d);
                cdata_wr_d = fold_s;
                csel_d     = SELW'(1 + CH) + SELW'(ch_d);
            end
            WR_L2: begin
                caddr_wr_d = l1_addr(r_d, c_d) * AW'(CH) + AW'(ch_d);
                csel_d     = SELW'(1 + 2 * CH);
            end
            default: csel_d = csel_q;
        endcase
    end

    // State, datapath and registered outputs; reset aborts any run in progress.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            r_q          <= '0;
            c_q          <= '0;
            ch_q         <= '0;
            k_q          <= '0;
            flat_q       <= 1'b0;
            busy_q       <= 1'b0;
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            acc_q        <= '0;
            crd_q        <= 1'b0;
            cwr_q        <= 1'b0;
            caddr_rd_q   <= '0;
            caddr_wr_q   <= '0;
            cdata_wr_q   <= '0;
            csel_q       <= '0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            ch_q         <= ch_d;
            k_q          <= k_d;
            flat_q       <= flat_d;
            busy_q       <= busy_d;
            pend_q       <= crd_q;
            pend_first_q <= crd_q && (k_q == '0);
            acc_q        <= fold_s;
            crd_q        <= crd_d;
            cwr_q        <= cwr_d;
            caddr_rd_q   <= caddr_rd_d;
            caddr_wr_q   <= caddr_wr_d;
            cdata_wr_q   <= cdata_wr_d;
            csel_q       <= csel_d;
        end
    end

    assign busy_o     = busy_q;
    assign crd_o      = crd_q;
    assign cwr_o      = cwr_q;
    assign caddr_rd_o = caddr_rd_q;
    assign caddr_wr_o = caddr_wr_q;
    assign cdata_wr_o = cdata_wr_q;
    assign csel_o     = csel_q;

endmodule

// File: tb/tb_maxpool_flatten_engine.sv
// Bench: default engine (64x64, 2x2, 2 ch) and a 16x16, 4x4, 3 ch engine with
// behavioural memories, a write scoreboard and table-driven memory checks.
module tb_maxpool_flatten_engine;

    typedef logic [34:0] wr_t;
    typedef struct {
        int          sel;
        int          addr;
        logic [19:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready_a = 1'b0, flat_a = 1'b0, ready_b = 1'b0, flat_b = 1'b0;
    logic busy_a, crd_a, cwr_a, busy_b, crd_b, cwr_b;
    logic [11:0] caddr_rd_a, caddr_wr_a;
    logic [7:0]  caddr_rd_b, caddr_wr_b;
    logic [19:0] rdata_a = 20'd0, rdata_b = 20'd0, cdata_wr_a, cdata_wr_b;
    logic [2:0]  csel_a, csel_b;

    logic [19:0] mem_a  [0:7][0:4095];
    logic [19:0] snap_a [0:7][0:4095];
    logic [19:0] mem_b  [0:7][0:255];
    wr_t sb_a[$];
    wr_t sb_b[$];
    int  seq_b[$];
    int  checks = 0, errors = 0;
    int  mode = 0, viol = 0, l2w_a = 0, run_b = 0, runs_b = 0, badrun_b = 0;

    maxpool_flatten_engine dut_a (
        .clk_i(clk), .reset_i(rst), .ready_i(ready_a), .flat_en_i(flat_a), .busy_o(busy_a),
        .crd_o(crd_a), .caddr_rd_o(caddr_rd_a), .cdata_rd_i(rdata_a), .cwr_o(cwr_a),
        .caddr_wr_o(caddr_wr_a), .cdata_wr_o(cdata_wr_a), .csel_o(csel_a)
    );

    maxpool_flatten_engine #(.IMG_W(16), .POOL(4), .CH(3), .SELW(3)) dut_b (
        .clk_i(clk), .reset_i(rst), .ready_i(ready_b), .flat_en_i(flat_b), .busy_o(busy_b),
        .crd_o(crd_b), .caddr_rd_o(caddr_rd_b), .cdata_rd_i(rdata_b), .cwr_o(cwr_b),
        .caddr_wr_o(caddr_wr_b), .cdata_wr_o(cdata_wr_b), .csel_o(csel_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Layer-0 contents: engine A ramps (ch0 a, ch1 4095-a, mode 1 plants signed windows),
    // engine B ch X holds a + X*256.
    function automatic logic [19:0] l0_word(input int which, input int sel, input int addr);
        int ch;
        ch = sel - 1;
        if (which == 1) return 20'(ch * 256 + addr);
        if (mode == 1 && ch == 0) begin
            case (addr)
                0:       return 20'hFFFFB;
                1:       return 20'hFFFFD;
                64:      return 20'hFFFF9;
                65:      return 20'hFFFFF;
                2:       return 20'h7FFFF;
                3:       return 20'h80000;
                66, 67:  return 20'h00000;
                default: ;
            endcase
        end
        return (ch == 0) ? 20'(addr) : 20'(4095 - addr);
    endfunction

    // Reference: expected write stream for a whole run, in r / c / ch order.
    task automatic push_expected(input int which, input logic flat);
        int img, pool, nch, ow;
        logic [19:0] m, v;
        wr_t e;
        img = (which == 1) ? 16 : 64;
        pool = (which == 1) ? 4 : 2;
        nch = (which == 1) ? 3 : 2;
        ow = img / pool;
        for (int r = 0; r < ow; r++)
            for (int c = 0; c < ow; c++)
                for (int ch = 0; ch < nch; ch++) begin
                    m = l0_word(which, 1 + ch, r * pool * img + c * pool);
                    for (int i = 0; i < pool; i++)
                        for (int j = 0; j < pool; j++) begin
                            v = l0_word(which, 1 + ch, (r * pool + i) * img + c * pool + j);
                            if ($signed(v) > $signed(m)) m = v;
                        end
                    e = {3'(1 + nch + ch), 12'(r * ow + c), m};
                    if (which == 1) sb_b.push_back(e); else sb_a.push_back(e);
                    if (flat) begin
                        e = {3'(1 + 2 * nch), 12'((r * ow + c) * nch + ch), m};
                        if (which == 1) sb_b.push_back(e); else sb_a.push_back(e);
                    end
                end
    endtask

    task automatic run(input int which, input logic flat, input int exp_n);
        int n;
        push_expected(which, flat);
        if (which == 1) begin ready_b = 1'b1; flat_b = flat; end
        else begin ready_a = 1'b1; flat_a = flat; end
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
        n = 0;
        while (((which == 1) ? busy_b : busy_a) && n < 20000) begin
            n++;
            @(negedge clk);
        end
        chk((which == 1) ? "b_busy_cycles" : "a_busy_cycles", 64'(n), 64'(exp_n));
        chk("sb_drained", 64'((which == 1) ? sb_b.size() : sb_a.size()), 64'd0);
    endtask

    function automatic logic a_zero();
        return !busy_a && !crd_a && !cwr_a && caddr_rd_a == 12'd0 && caddr_wr_a == 12'd0 &&
               cdata_wr_a == 20'd0 && csel_a == 3'd0;
    endfunction

    initial begin
        vec_t vecs[8];
        int n, bad, diffs, l2w0;
        int exp_seq[9];
        vecs[0] = '{3, 0, 20'd65};    vecs[1] = '{4, 0, 20'd4095};
        vecs[2] = '{3, 1023, 20'd4095}; vecs[3] = '{4, 1023, 20'd65};
        vecs[4] = '{5, 0, 20'd65};    vecs[5] = '{5, 1, 20'd4095};
        vecs[6] = '{5, 2046, 20'd4095}; vecs[7] = '{5, 2047, 20'd65};
        exp_seq = '{1, 4, 7, 2, 5, 7, 3, 6, 7};

        fork
            // Memory read port: one-cycle latency.
            forever begin
                @(posedge clk);
                if (crd_a) rdata_a <= l0_word(0, int'(csel_a), int'(caddr_rd_a));
                if (crd_b) rdata_b <= l0_word(1, int'(csel_b), int'(caddr_rd_b));
            end
            // Write port, scoreboard and bus-protocol monitors.
            forever begin
                wr_t e;
                @(negedge clk);
                if (crd_a && cwr_a) viol++;
                if (crd_b && cwr_b) viol++;
                if (cwr_a) begin
                    mem_a[csel_a][caddr_wr_a] = cdata_wr_a;
                    if (csel_a == 3'd5) l2w_a++;
                    chk("a_sb_has_entry", 64'(sb_a.size() != 0), 64'd1);
                    if (sb_a.size() != 0) begin
                        e = sb_a.pop_front();
                        chk("a_write", 64'({csel_a, caddr_wr_a, cdata_wr_a}), 64'(e));
                    end
                end
                if (cwr_b) begin
                    mem_b[csel_b][caddr_wr_b] = cdata_wr_b;
                    chk("b_sb_has_entry", 64'(sb_b.size() != 0), 64'd1);
                    if (sb_b.size() != 0) begin
                        e = sb_b.pop_front();
                        chk("b_write", 64'({csel_b, 4'd0, caddr_wr_b, cdata_wr_b}), 64'(e));
                    end
                end
                if ((crd_b || cwr_b) && seq_b.size() < 9 &&
                    (seq_b.size() == 0 || seq_b[$] != int'(csel_b)))
                    seq_b.push_back(int'(csel_b));
                if (crd_b) run_b++;
                else if (run_b > 0) begin
                    if (run_b != 16) badrun_b++;
                    runs_b++;
                    run_b = 0;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("a_reset_outputs", 64'(a_zero()), 64'd1);
        chk("b_reset_outputs", 64'({busy_b, crd_b, cwr_b, caddr_rd_b, caddr_wr_b, cdata_wr_b, csel_b}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp data with flatten enabled.
        run(0, 1'b1, 14336);
        for (int i = 0; i < 8; i++)
            chk($sformatf("mem_sel%0d_addr%0d", vecs[i].sel, vecs[i].addr),
                64'(mem_a[vecs[i].sel][vecs[i].addr]), 64'(vecs[i].exp));

        // Reset 100 cycles into a run, then a flatten-off rerun.
        push_expected(0, 1'b0);
        ready_a = 1'b1;
        flat_a = 1'b0;
        @(negedge clk);
        ready_a = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs_cleared", 64'(a_zero()), 64'd1);
        rst = 1'b0;
        sb_a.delete();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!a_zero()) bad++;
        end
        chk("abort_stays_idle", 64'(bad), 64'd0);
        snap_a = mem_a;
        l2w0 = l2w_a;
        run(0, 1'b0, 12288);
        diffs = 0;
        for (int s = 3; s <= 5; s++)
            for (int a = 0; a < 4096; a++)
                if (mem_a[s][a] !== snap_a[s][a]) diffs++;
        chk("rerun_l1_l2_unchanged", 64'(diffs), 64'd0);
        chk("flat_off_no_l2_writes", 64'(l2w_a - l2w0), 64'd0);

        // ready held high across completion; flat_en toggled mid-run.
        push_expected(0, 1'b1);
        ready_a = 1'b1;
        flat_a = 1'b1;
        @(negedge clk);
        flat_a = 1'b0;
        n = 0;
        while (busy_a && n < 20000) begin n++; @(negedge clk); end
        chk("b2b_first_busy", 64'(n), 64'd14336);
        chk("b2b_first_drained", 64'(sb_a.size()), 64'd0);
        push_expected(0, 1'b0);
        @(negedge clk);
        chk("b2b_one_idle_cycle", 64'(busy_a), 64'd1);
        ready_a = 1'b0;
        n = 0;
        while (busy_a && n < 20000) begin n++; @(negedge clk); end
        chk("b2b_second_busy", 64'(n), 64'd12288);
        chk("b2b_second_drained", 64'(sb_a.size()), 64'd0);

        // Signed maximum windows.
        mode = 1;
        run(0, 1'b0, 12288);
        chk("signed_neg_window", 64'(mem_a[3][0]), 64'h0FFFFF);
        chk("signed_extreme_window", 64'(mem_a[3][1]), 64'h07FFFF);

        // 16x16 image, 4x4 pool, 3 channels.
        run(1, 1'b1, 912);
        for (int x = 0; x < 3; x++)
            chk($sformatf("b_l1ch%0d_0", x), 64'(mem_b[4 + x][0]), 64'(51 + x * 256));
        chk("b_csel_seq_len", 64'(seq_b.size()), 64'd9);
        for (int i = 0; i < 9 && i < seq_b.size(); i++)
            chk($sformatf("b_csel_seq%0d", i), 64'(seq_b[i]), 64'(exp_seq[i]));
        chk("b_read_bursts_16", 64'(badrun_b), 64'd0);
        chk("b_read_burst_count", 64'(runs_b), 64'd48);
        chk("crd_cwr_exclusive", 64'(viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
